// File: rtl/bsg_manycore_edge_arb.sv
// Round-robin share of one mesh edge link among requesters, with per-requester outstanding limits.
// Latency 1 cycle input-to-v_o; no grant while the output stage is full and ready_i is low.
module bsg_manycore_edge_arb #(
    parameter int num_req_p      = 4,
    parameter int packet_width_p = 32,
    parameter int max_out_p      = 4,
    parameter int id_width_lp    = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    parameter int cnt_width_lp   = (max_out_p + 1 > 1) ? $clog2(max_out_p + 1) : 1
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_req_p*packet_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]                req_v_i,
    output logic [num_req_p-1:0]                req_ready_o,
    output logic [packet_width_p-1:0]           data_o,
    output logic                                v_o,
    input  logic                                ready_i,
    input  logic                                ret_v_i,
    input  logic [id_width_lp-1:0]              ret_id_i,
    output logic [num_req_p*cnt_width_lp-1:0]   out_cnt_o,
    output logic                                idle_o,
    output logic                                err_o
);

    logic [packet_width_p-1:0] data_q;
    logic                      v_q;
    logic [id_width_lp-1:0]    rr_q;
    logic [cnt_width_lp-1:0]   cnt_q [num_req_p];
    logic                      err_q;

    logic                      can_load;
    logic [num_req_p-1:0]      eligible;
    logic [num_req_p-1:0]      grant;
    logic                      grant_any;
    logic [id_width_lp-1:0]    grant_id;
    logic                      found;
    int                        idx;

    logic [31:0]               ret_id_ext;
    logic                      ret_bad_id;
    logic                      ret_underflow;
    logic [num_req_p-1:0]      ret_dec;
    logic                      cnt_all_zero;

    assign can_load = ~v_q | ready_i;

    // Eligibility looks only at the registered count, so a same-cycle return cannot unlock a grant.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < num_req_p; i++) begin
            eligible[i] = req_v_i[i] & (cnt_q[i] < cnt_width_lp'(max_out_p));
        end
    end

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < num_req_p; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!found && eligible[idx]) begin
                found    = 1'b1;
                grant_id = id_width_lp'(idx);
            end
        end
        if (found && can_load && !reset_i) grant[grant_id] = 1'b1;
    end

    assign grant_any   = |grant;
    assign req_ready_o = grant;

    // Returns: decode per requester; out-of-range ids and underflows only flag an error.
    assign ret_id_ext = 32'(ret_id_i);
    assign ret_bad_id = ret_v_i & (ret_id_ext >= 32'(num_req_p));

    always_comb begin
        ret_dec       = '0;
        ret_underflow = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            if (ret_v_i && ret_id_ext == 32'(i)) begin
                if (cnt_q[i] != '0) ret_dec[i] = 1'b1;
                else                ret_underflow = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
            v_q    <= 1'b0;
            rr_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            if (grant_any) begin
                data_q <= req_data_i[grant_id*packet_width_p +: packet_width_p];
                v_q    <= 1'b1;
                rr_q   <= (int'(grant_id) == num_req_p - 1) ? '0 : grant_id + 1'b1;
            end else if (ready_i) begin
                v_q <= 1'b0;
            end
            if (ret_bad_id || ret_underflow) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < num_req_p; i++) begin
            if (reset_i) begin
                cnt_q[i] <= '0;
            end else if (grant[i] && !ret_dec[i]) begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end else if (!grant[i] && ret_dec[i]) begin
                cnt_q[i] <= cnt_q[i] - 1'b1;
            end
        end
    end

    always_comb begin
        cnt_all_zero = 1'b1;
        out_cnt_o    = '0;
        for (int i = 0; i < num_req_p; i++) begin
            out_cnt_o[i*cnt_width_lp +: cnt_width_lp] = cnt_q[i];
            if (cnt_q[i] != '0) cnt_all_zero = 1'b0;
        end
    end

    assign data_o = data_q;
    assign v_o    = v_q;
    assign err_o  = err_q;
    assign idle_o = ~v_q & cnt_all_zero;

endmodule

// File: tb/tb_bsg_manycore_edge_arb.sv
// Directed bench for bsg_manycore_edge_arb: 4 requesters, 8-bit packets, max 4 outstanding.
module tb_bsg_manycore_edge_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int M  = 4;
    localparam int IW = 2;
    localparam int CW = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*W-1:0]  req_data = '0;
    logic [N-1:0]    req_v = '0;
    logic [N-1:0]    req_ready;
    logic [W-1:0]    data;
    logic            v;
    logic            ready = 1'b1;
    logic            ret_v = 1'b0;
    logic [IW-1:0]   ret_id = '0;
    logic [N*CW-1:0] out_cnt;
    logic            idle;
    logic            err;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bsg_manycore_edge_arb #(
        .num_req_p(N), .packet_width_p(W), .max_out_p(M)
    ) dut (
        .clk_i(clk), .reset_i(reset),
        .req_data_i(req_data), .req_v_i(req_v), .req_ready_o(req_ready),
        .data_o(data), .v_o(v), .ready_i(ready),
        .ret_v_i(ret_v), .ret_id_i(ret_id),
        .out_cnt_o(out_cnt), .idle_o(idle), .err_o(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int i);
        return 32'(out_cnt[i*CW +: CW]);
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset: grants suppressed even with all valid.
        req_v = 4'b1111;
        tick();
        chk("rst_ready", 32'(req_ready), 32'h0);
        tick();
        reset = 1'b0;
        req_v = '0;
        chk("rst_v", 32'(v), 32'h0);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_err", 32'(err), 32'h0);
        for (int i = 0; i < N; i++) chk("rst_cnt", cnt(i), 32'h0);

        // Single requester.
        req_data[0*W +: W] = 8'hA5;
        req_v = 4'b0001;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        tick();
        req_v = '0;
        chk("t1_v", 32'(v), 32'h1);
        chk("t1_data", 32'(data), 32'hA5);
        chk("t1_cnt0", cnt(0), 32'h1);
        chk("t1_idle", 32'(idle), 32'h0);
        tick();
        chk("t1_drain", 32'(v), 32'h0);

        // Round robin across all four until every count saturates.
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'hB0 + i);
        req_v = 4'b1111;
        ready = 1'b1;
        for (int g = 0; g < 16; g++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(1 << (g % 4)));
            tick();
            chk("rr_data", 32'(data), 32'(8'hB0 + (g % 4)));
        end
        chk("rr_sat_ready", 32'(req_ready), 32'h0);
        chk("rr_v_hold", 32'(v), 32'h1);
        for (int i = 0; i < N; i++) chk("rr_cnt4", cnt(i), 32'h4);
        tick();
        chk("rr_v_drop", 32'(v), 32'h0);
        chk("rr_idle", 32'(idle), 32'h0);

        // Backpressure.
        do_reset();
        req_v = 4'b0001;
        req_data[0*W +: W] = 8'h11;
        tick();
        chk("bp_load", 32'(data), 32'h11);
        ready = 1'b0;
        req_data[0*W +: W] = 8'h22;
        req_data[1*W +: W] = 8'h33;
        req_v = 4'b0011;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'h0);
            tick();
            chk("bp_data", 32'(data), 32'h11);
            chk("bp_v", 32'(v), 32'h1);
        end
        ready = 1'b1;
        #1;
        chk("bp_release", 32'(req_ready), 32'h2);
        tick();
        chk("bp_new_data", 32'(data), 32'h33);
        chk("bp_cnt1", cnt(1), 32'h1);

        // Requester 2 saturates, then a return reopens it one cycle later.
        req_v = 4'b0100;
        req_data[2*W +: W] = 8'h44;
        for (int g = 0; g < 4; g++) begin
            #1;
            chk("r2_grant", 32'(req_ready), 32'h4);
            tick();
        end
        chk("r2_cnt4", cnt(2), 32'h4);
        ret_v = 1'b1;
        ret_id = 2'd2;
        #1;
        chk("r2_no_same_cycle", 32'(req_ready), 32'h0);
        tick();
        ret_v = 1'b0;
        chk("r2_cnt3", cnt(2), 32'h3);
        chk("r2_regrant", 32'(req_ready), 32'h4);
        tick();
        chk("r2_cnt4_again", cnt(2), 32'h4);

        // Grant and return for requester 1 in the same cycle.
        req_v = 4'b0010;
        tick();
        chk("r1_cnt2", cnt(1), 32'h2);
        ret_v = 1'b1;
        ret_id = 2'd1;
        #1;
        chk("r1_grant", 32'(req_ready), 32'h2);
        tick();
        ret_v = 1'b0;
        req_v = '0;
        chk("r1_cnt_same", cnt(1), 32'h2);

        // Underflow return sets sticky error.
        chk("err_pre", 32'(err), 32'h0);
        ret_v = 1'b1;
        ret_id = 2'd3;
        tick();
        ret_v = 1'b0;
        chk("err_set", 32'(err), 32'h1);
        chk("err_cnt3", cnt(3), 32'h0);
        tick();
        chk("err_sticky", 32'(err), 32'h1);

        // Reset mid-traffic.
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'hC0 + i);
        req_v = 4'b1111;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        reset = 1'b0;
        chk("mid_err", 32'(err), 32'h0);
        chk("mid_v", 32'(v), 32'h0);
        chk("mid_idle", 32'(idle), 32'h1);
        for (int i = 0; i < N; i++) chk("mid_cnt", cnt(i), 32'h0);
        #1;
        chk("mid_first_grant", 32'(req_ready), 32'h1);
        tick();
        chk("mid_data", 32'(data), 32'hC0);
        req_v = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
